// File: rtl/timer_arbiter.sv
// Shared down-counter timer arbitrated round-robin between two requesters.
// A requester holds its req high to run a delay of len+1 count cycles; dropping req aborts.
module timer_arbiter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic [CNT_WIDTH-1:0] len0,
    input  logic                 req1,
    input  logic [CNT_WIDTH-1:0] len1,
    output logic                 grant0,
    output logic                 grant1,
    output logic                 done0,
    output logic                 done1,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COUNT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 last_q, last_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 grant0_q, grant0_d;
    logic                 grant1_q, grant1_d;
    logic                 done0_q, done0_d;
    logic                 done1_q, done1_d;
    logic                 winner;
    logic                 owner_req;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        winner    = 1'b0;
        owner_req = owner_q ? req1 : req0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On contention the requester not served last wins.
                    winner  = (req0 && req1) ? ~last_q : req1;
                    owner_d = winner;
                    last_d  = winner;
                    cnt_d   = winner ? len1 : len0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Grant/done flops are loaded from the next state so they line up with state_q.
        grant0_d = (state_d != IDLE) && !owner_d;
        grant1_d = (state_d != IDLE) &&  owner_d;
        done0_d  = (state_d == DONE) && !owner_d;
        done1_d  = (state_d == DONE) &&  owner_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            grant0_q <= 1'b0;
            grant1_q <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            grant0_q <= grant0_d;
            grant1_q <= grant1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
        end
    end

    assign grant0 = grant0_q;
    assign grant1 = grant1_q;
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign busy   = (state_q != IDLE);
    assign cnt    = cnt_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: a per-cycle vector table plus hand-written
// sequences for async reset, long counts and length changes mid-count.
module tb_timer_arbiter;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         req0, req1;
    logic [W-1:0] len0, len1;
    logic         grant0, grant1, done0, done1, busy;
    logic [W-1:0] cnt;

    int checks = 0;
    int errors = 0;

    timer_arbiter #(.CNT_WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req0),
        .len0   (len0),
        .req1   (req1),
        .len1   (len1),
        .grant0 (grant0),
        .grant1 (grant1),
        .done0  (done0),
        .done1  (done1),
        .busy   (busy),
        .cnt    (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         r0;
        logic         r1;
        logic [W-1:0] l0;
        logic [W-1:0] l1;
        logic [12:0]  exp;   // {grant0, grant1, done0, done1, busy, cnt}
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r0, input logic r1, input int l0, input int l1,
                                input logic g0, input logic g1, input logic d0, input logic d1,
                                input logic b, input int c);
        vec_t v;
        v.r0  = r0;
        v.r1  = r1;
        v.l0  = W'(l0);
        v.l1  = W'(l1);
        v.exp = {g0, g1, d0, d1, b, W'(c)};
        return v;
    endfunction

    function automatic logic [12:0] outs();
        return {grant0, grant1, done0, done1, busy, cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end else begin
            $display("ok   %s: %0h", name, got);
        end
    endtask

    // Run requester 0 from IDLE; optionally change len0 after cycle change_at.
    task automatic measure(input int l, input int change_at, input int l2,
                           output int done_cyc, output int grant_cyc, output int done_cnt);
        done_cyc  = -1;
        grant_cyc = 0;
        done_cnt  = 0;
        req0 = 1'b1;
        len0 = W'(l);
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk);
            #1;
            if (grant0) grant_cyc++;
            if (done0) begin
                done_cyc = c;
                done_cnt = int'(cnt);
                break;
            end
            if (c == change_at) len0 = W'(l2);
        end
        req0 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, gc, dcnt;

        // Contention with strict alternation, then abort of owner 0.
        vecs[0]  = mk(1, 1, 1, 0,   1, 0, 0, 0, 1, 1);
        vecs[1]  = mk(1, 1, 1, 0,   1, 0, 0, 0, 1, 0);
        vecs[2]  = mk(1, 1, 1, 0,   1, 0, 1, 0, 1, 0);
        vecs[3]  = mk(1, 1, 1, 0,   0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 1, 1, 0,   0, 1, 0, 0, 1, 0);
        vecs[5]  = mk(1, 1, 1, 0,   0, 1, 0, 1, 1, 0);
        vecs[6]  = mk(1, 1, 1, 0,   0, 0, 0, 0, 0, 0);
        vecs[7]  = mk(1, 1, 1, 0,   1, 0, 0, 0, 1, 1);
        vecs[8]  = mk(0, 0, 1, 0,   0, 0, 0, 0, 0, 0);
        // Single len 3 with len0 wiggled mid-count and requester 1 held off.
        vecs[9]  = mk(1, 0, 3, 7,   1, 0, 0, 0, 1, 3);
        vecs[10] = mk(1, 1, 9, 7,   1, 0, 0, 0, 1, 2);
        vecs[11] = mk(1, 1, 0, 7,   1, 0, 0, 0, 1, 1);
        vecs[12] = mk(1, 1, 0, 7,   1, 0, 0, 0, 1, 0);
        vecs[13] = mk(1, 1, 0, 7,   1, 0, 1, 0, 1, 0);
        vecs[14] = mk(0, 1, 0, 7,   0, 0, 0, 0, 0, 0);
        // Requester 1 len 10, aborted; pointer stays at 1 so req0 wins next.
        vecs[15] = mk(0, 1, 0, 10,  0, 1, 0, 0, 1, 10);
        vecs[16] = mk(0, 1, 0, 10,  0, 1, 0, 0, 1, 9);
        vecs[17] = mk(0, 1, 0, 10,  0, 1, 0, 0, 1, 8);
        vecs[18] = mk(0, 0, 0, 10,  0, 0, 0, 0, 0, 0);
        vecs[19] = mk(1, 1, 2, 5,   1, 0, 0, 0, 1, 2);
        vecs[20] = mk(1, 1, 2, 5,   1, 0, 0, 0, 1, 1);
        vecs[21] = mk(1, 0, 2, 5,   1, 0, 0, 0, 1, 0);
        vecs[22] = mk(1, 0, 2, 5,   1, 0, 1, 0, 1, 0);
        vecs[23] = mk(1, 0, 2, 5,   0, 0, 0, 0, 0, 0);
        vecs[24] = mk(1, 0, 2, 5,   1, 0, 0, 0, 1, 2);
        vecs[25] = mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0);

        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        len0  = '0;
        len1  = '0;
        #1;
        check("reset_outputs", 32'(outs()), 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            req0 = vecs[i].r0;
            req1 = vecs[i].r1;
            len0 = vecs[i].l0;
            len1 = vecs[i].l1;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // Length changed from 5 to 1 after sampling: done still at cycle 7.
        measure(5, 2, 1, dc, gc, dcnt);
        check("lenchg_done_cycle", 32'(dc), 32'd7);
        check("lenchg_grant_cycles", 32'(gc), 32'd7);

        // Zero length: done at cycle 2.
        measure(0, 0, 0, dc, gc, dcnt);
        check("len0_done_cycle", 32'(dc), 32'd2);
        check("len0_grant_cycles", 32'(gc), 32'd2);

        // Maximum length: done at cycle 257, counter never wraps.
        measure(255, 0, 0, dc, gc, dcnt);
        check("max_done_cycle", 32'(dc), 32'd257);
        check("max_grant_cycles", 32'(gc), 32'd257);
        check("max_done_cnt", 32'(dcnt), 32'd0);
        check("after_max_idle", 32'(outs()), 32'h0);

        // Asynchronous reset mid-count.
        req0 = 1'b1;
        len0 = W'(200);
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk);
            #1;
        end
        check("midrun_cycle50", 32'(outs()), 32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd151}));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'(outs()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_grant", 32'(outs()), 32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd200}));
        req0 = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_abort", 32'(outs()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 8, width of the shared down-counter and of each length input (legal range 2..16).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req0  input  1  requester 0 timer request (level, held until done0 or abort).
REQ-005 SHALL have port len0  input  CNT_WIDTH  requester 0 delay length, sampled only on the grant cycle.
REQ-006 SHALL have port req1  input  1  requester 1 timer request (level).
REQ-007 SHALL have port len1  input  CNT_WIDTH  requester 1 delay length, sampled only on the grant cycle.
REQ-008 SHALL have port grant0  output  1  counter owned by requester 0 (registered).
REQ-009 SHALL have port grant1  output  1  counter owned by requester 1 (registered).
REQ-010 SHALL have port done0  output  1  one-cycle terminal-count pulse to requester 0 (registered).
REQ-011 SHALL have port done1  output  1  one-cycle terminal-count pulse to requester 1 (registered).
REQ-012 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-013 SHALL have port cnt  output  CNT_WIDTH  current shared down-counter value.

Function
REQ-014 SHALL implement FSM states IDLE, COUNT, DONE; exactly one active at any time.
REQ-015 IDLE: if any req high, SHALL grant one requester, load cnt <= len of winner, go COUNT; else stay IDLE, cnt holds.
REQ-016 Arbitration SHALL be round-robin: if only one req high it wins; if both high, winner is the requester not served last.
REQ-017 Last-served pointer SHALL update only on entry to COUNT, never on abort.
REQ-018 grantX SHALL be high in every COUNT and DONE cycle owned by X, low otherwise; grant0 and grant1 never high together.
REQ-019 COUNT: if owner req still high and cnt != 0, SHALL decrement cnt by 1 (no wrap below 0).
REQ-020 COUNT: if owner req high and cnt == 0, SHALL go DONE; cnt stays 0.
REQ-021 COUNT: if owner req low (abort), SHALL go IDLE next cycle, cnt cleared to 0, no done pulse.
REQ-022 DONE: doneX of owner SHALL be high for exactly this one cycle; next state always IDLE regardless of req.
REQ-023 Latency: req seen in IDLE at edge N -> grant high from N+1; doneX high in cycle N+len+2; grant high len+2 cycles total.
REQ-024 len = 0 SHALL give COUNT for one cycle then DONE (done at N+2).
REQ-025 Request still high in IDLE after DONE SHALL re-arbitrate normally (periodic reuse); with both high, the other requester wins.
REQ-026 Changes on lenX outside the grant cycle SHALL have no effect on a running count.
REQ-027 Requests arriving during COUNT/DONE from the non-owner SHALL be held off (no grant) until the next IDLE cycle.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, cnt=0, grant0=grant1=0, done0=done1=0, busy=0.
REQ-029 Reset SHALL set last-served pointer to requester 1, so requester 0 wins the first simultaneous request.
REQ-030 Reset asserted mid-COUNT SHALL abort immediately with no done pulse; after release, arbitration restarts from IDLE.

Verification
REQ-031 Single: req0=1, len0=3 at cycle 0 -> grant0 cycles 1-5, cnt 3,2,1,0,0, done0 only cycle 5, busy cycles 1-5.
REQ-032 Contention: req0=req1=1 after reset, held -> grant0 first, then after one IDLE cycle grant1, then grant0 (strict alternation).
REQ-033 Abort: req1=1, len1=10, drop req1 at cycle 4 -> grant1 low from cycle 5, done1 never, cnt=0, idle, pointer=1 unchanged.
REQ-034 Zero length: req0=1, len0=0 -> grant0 cycles 1-2, done0 cycle 2, cnt 0 throughout.
REQ-035 Reset mid-run: len0=200 (CNT_WIDTH=8), assert rst_n=0 at cycle 50 -> all outputs 0 asynchronously; release, req0 high -> new grant0 one cycle after first active edge.
REQ-036 Len change: len0 changed from 5 to 1 during COUNT -> done0 still at cycle 7; max len 255 -> done at cycle 257, no wrap.
